// File: rtl/bn_dmux_seq.sv
`default_nettype none
// ============================================================================
// Module   : bn_dmux_seq
// Brief    : Upstream sequencer for the 1-to-3 16-bit demultiplexer in the
//            systolic BN datapath. Sorts a valid/ready sample stream into
//            three consecutive passes of BATCH_SIZE samples each:
//              pass 0 -> statistics/mean lane  (sel = 2'b00)
//              pass 1 -> range lane            (sel = 2'b01)
//              pass 2 -> normalize lane        (sel = 2'b10)
//            sel = 2'b11 parks the demux on idle (all lanes zero).
// Ports    : clk, rst       - clock, synchronous active-high reset
//            start, abort   - begin a sequence (IDLE only) / return to IDLE
//            in_valid, in_ready, in_data    - upstream sample handshake
//            sel, out_data, out_valid       - registered demux drive
//            pass_idx, busy, done           - registered status
// Revision : 1.0 - initial release
// ============================================================================
module bn_dmux_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int BATCH_SIZE = 16,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [1:0]            sel,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic [1:0]            pass_idx,
    output logic                  busy,
    output logic                  done
);

    localparam logic [2:0]       S_IDLE     = 3'd0;
    localparam logic [2:0]       S_PASS0    = 3'd1;
    localparam logic [2:0]       S_PASS1    = 3'd2;
    localparam logic [2:0]       S_PASS2    = 3'd3;
    localparam logic [2:0]       S_DONE     = 3'd4;

    localparam logic [1:0]       C_SEL_IDLE = 2'b11;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(BATCH_SIZE - 1);

    logic [2:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [1:0]            r_sel;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic [1:0]            r_pass_idx;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_in_pass;
    logic                  w_accept;
    logic                  w_last;
    logic [1:0]            w_pass_code;
    logic [2:0]            w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [1:0]            w_pass_idx_nxt;
    logic                  w_busy_nxt;

    assign w_in_pass = (r_state == S_PASS0) || (r_state == S_PASS1) ||
                       (r_state == S_PASS2);

    // rst is folded in so nothing upstream sees a handshake during reset.
    assign in_ready  = w_in_pass && !abort && !rst;
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_cnt == C_CNT_LAST);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_pass_code    = C_SEL_IDLE;
        w_pass_idx_nxt = 2'd0;
        w_busy_nxt     = 1'b0;

        case (r_state)
            S_PASS0: w_pass_code = 2'b00;
            S_PASS1: w_pass_code = 2'b01;
            S_PASS2: w_pass_code = 2'b10;
            default: w_pass_code = C_SEL_IDLE;
        endcase

        if (abort) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_nxt = S_PASS0;
                        w_cnt_nxt   = '0;
                    end
                end
                S_PASS0, S_PASS1, S_PASS2: begin
                    if (w_accept) begin
                        if (w_last) begin
                            // Advance on the final accept so the next pass
                            // can take a sample on the very next cycle.
                            w_cnt_nxt = '0;
                            case (r_state)
                                S_PASS0: w_state_nxt = S_PASS1;
                                S_PASS1: w_state_nxt = S_PASS2;
                                default: w_state_nxt = S_DONE;
                            endcase
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        // Status registers track the state they will sit beside.
        case (w_state_nxt)
            S_PASS0: begin w_pass_idx_nxt = 2'd0; w_busy_nxt = 1'b1; end
            S_PASS1: begin w_pass_idx_nxt = 2'd1; w_busy_nxt = 1'b1; end
            S_PASS2: begin w_pass_idx_nxt = 2'd2; w_busy_nxt = 1'b1; end
            default: begin w_pass_idx_nxt = 2'd0; w_busy_nxt = 1'b0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_sel       <= C_SEL_IDLE;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_pass_idx  <= 2'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pass_idx <= w_pass_idx_nxt;
            r_busy     <= w_busy_nxt;
            // Lands in the same cycle as the last pass-2 sample on the outputs.
            r_done     <= (w_state_nxt == S_DONE);

            // sel and data share one register stage so they never skew;
            // without an accept the demux is parked on zeros.
            if (w_accept) begin
                r_sel       <= w_pass_code;
                r_out_data  <= in_data;
                r_out_valid <= 1'b1;
            end else begin
                r_sel       <= C_SEL_IDLE;
                r_out_data  <= '0;
                r_out_valid <= 1'b0;
            end
        end
    end

    assign sel       = r_sel;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign pass_idx  = r_pass_idx;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bn_dmux_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bn_dmux_seq
// Brief    : Directed self-checking bench for bn_dmux_seq. Instance a uses
//            BATCH_SIZE=4, instance b uses BATCH_SIZE=2; both share stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bn_dmux_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        in_valid;
    logic [15:0] in_data;

    logic        in_ready_a, out_valid_a, busy_a, done_a;
    logic [1:0]  sel_a, pass_idx_a;
    logic [15:0] out_data_a;

    logic        in_ready_b, out_valid_b, busy_b, done_b;
    logic [1:0]  sel_b, pass_idx_b;
    logic [15:0] out_data_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bn_dmux_seq #(.DATA_WIDTH(16), .BATCH_SIZE(4), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .sel(sel_a), .out_data(out_data_a), .out_valid(out_valid_a),
        .pass_idx(pass_idx_a), .busy(busy_a), .done(done_a)
    );

    bn_dmux_seq #(.DATA_WIDTH(16), .BATCH_SIZE(2), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .sel(sel_b), .out_data(out_data_b), .out_valid(out_valid_b),
        .pass_idx(pass_idx_b), .busy(busy_b), .done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = 16'h0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        check({tag, ".sel"},      32'(sel_a),       32'h3);
        check({tag, ".valid"},    32'(out_valid_a), 32'h0);
        check({tag, ".data"},     32'(out_data_a),  32'h0);
        check({tag, ".busy"},     32'(busy_a),      32'h0);
        check({tag, ".pass_idx"}, 32'(pass_idx_a),  32'h0);
        check({tag, ".done"},     32'(done_a),      32'h0);
    endtask

    // Start pulse plus samples 1..12 on instance a; ends in the DONE cycle.
    task automatic run_seq(input bit gapped, input bit poke_start);
        start = 1'b1;
        step();
        start = 1'b0;
        check("seq.busy0", 32'(busy_a), 32'h1);
        check("seq.sel0",  32'(sel_a),  32'h3);
        for (int i = 1; i <= 12; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i);
            start    = poke_start && (i == 6);
            #1;
            check("seq.ready", 32'(in_ready_a), 32'h1);
            step();
            in_valid = 1'b0;
            start    = 1'b0;
            check("seq.sel",      32'(sel_a),       32'((i - 1) / 4));
            check("seq.data",     32'(out_data_a),  32'(i));
            check("seq.valid",    32'(out_valid_a), 32'h1);
            check("seq.done",     32'(done_a),      32'(i == 12));
            check("seq.pass_idx", 32'(pass_idx_a),  (i == 12) ? 32'h0 : 32'(i / 4));
            check("seq.busy",     32'(busy_a),      32'(i != 12));
            if (gapped && i != 12) begin
                step();
                check("gap.sel",   32'(sel_a),       32'h3);
                check("gap.valid", 32'(out_valid_a), 32'h0);
                check("gap.data",  32'(out_data_a),  32'h0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        do_reset();
        chk_idle("rst");
        check("rst.ready", 32'(in_ready_a), 32'h0);

        // Full back-to-back sequence
        run_seq(1'b0, 1'b0);
        step();
        chk_idle("full.post");

        // Gapped input with a stray start during PASS1
        run_seq(1'b1, 1'b1);

        // start in the DONE cycle must not relaunch
        start = 1'b1;
        step();
        start = 1'b0;
        chk_idle("donestart");
        step();
        chk_idle("donestart2");

        // Valid sample in IDLE is ignored
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        #1;
        check("idle.ready", 32'(in_ready_a), 32'h0);
        step();
        in_valid = 1'b0;
        check("idle.valid", 32'(out_valid_a), 32'h0);
        check("idle.data",  32'(out_data_a),  32'h0);

        // Abort after two pass-1 accepts
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(16'h0100 + i);
            step();
        end
        check("abt.sel",  32'(sel_a),      32'h1);
        check("abt.data", 32'(out_data_a), 32'h0106);
        abort    = 1'b1;
        in_data  = 16'hDEAD;
        #1;
        check("abt.ready", 32'(in_ready_a), 32'h0);
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk_idle("abort");
        run_seq(1'b0, 1'b0);
        step();
        chk_idle("abt.post");

        // Reset during PASS2
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(16'h0200 + i);
            step();
        end
        check("mrst.pass_idx", 32'(pass_idx_a), 32'h2);
        rst     = 1'b1;
        in_data = 16'h5555;
        #1;
        check("mrst.ready", 32'(in_ready_a), 32'h0);
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk_idle("mrst");
        step();
        chk_idle("mrst2");
        run_seq(1'b0, 1'b0);
        step();
        chk_idle("mrst.post");

        // BATCH_SIZE=2 boundary on instance b
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(16'h0020 + i);
            step();
            check("bs2.sel",   32'(sel_b),       32'((i - 1) / 2));
            check("bs2.valid", 32'(out_valid_b), 32'h1);
            check("bs2.data",  32'(out_data_b),  32'(16'h0020 + i));
            check("bs2.done",  32'(done_b),      32'(i == 6));
        end
        in_valid = 1'b0;
        step();
        check("bs2.idle_sel", 32'(sel_b),  32'h3);
        check("bs2.busy",     32'(busy_b), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
